// File: rtl/arithmetic_pkg.sv
// Shared encodings and state types for the execute-stage ALU and iterative mul/div unit.
package arithmetic_pkg;

    // funct3 encodings for the base register-register operations
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // How an accepted operation is retired
    typedef enum logic [1:0] {
        K_ILLEGAL,
        K_QUICK,
        K_ITER
    } kind_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iterative.sv
// Shared multi-cycle datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a combinational sign fix-up on the last cycle.
module muldiv_iterative
    import arithmetic_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic              active;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;

    logic              lhs_sgn;
    logic              rhs_sgn;
    logic              lhs_neg;
    logic              rhs_neg;
    logic [XLEN-1:0]   lhs_mag;
    logic [XLEN-1:0]   rhs_mag;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     rsh;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] step_mul;
    logic [2*XLEN-1:0] step_div;

    // acc holds {high, low} of the product, or {remainder, quotient} for divide
    function automatic logic [XLEN-1:0] fixup(
        input logic [2:0]      f3,
        input logic [2*XLEN-1:0] a,
        input logic            nq,
        input logic            nr
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = nq ? -a : a;
        quo  = a[XLEN-1:0];
        rem  = a[2*XLEN-1:XLEN];
        case (f3)
            F3_MUL:                        return prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  return prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               return nq ? -quo : quo;
            default:                       return nr ? -rem : rem;
        endcase
    endfunction

    always_comb begin
        lhs_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
               || (funct3 == F3_DIV)  || (funct3 == F3_REM);
        rhs_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        lhs_neg = lhs_sgn && lhs[XLEN-1];
        rhs_neg = rhs_sgn && rhs[XLEN-1];
        lhs_mag = lhs_neg ? -lhs : lhs;
        rhs_mag = rhs_neg ? -rhs : rhs;
    end

    always_comb begin
        msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        rsh      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        trial    = rsh - {1'b0, opnd};
        step_mul = {msum, acc[XLEN-1:1]};
        step_div = {(trial[XLEN] ? rsh[XLEN-1:0] : trial[XLEN-1:0]),
                    acc[XLEN-2:0], ~trial[XLEN]};
    end

    assign done   = active && (count == CW'(XLEN));
    assign result = fixup(op, acc, neg_q, neg_r);

    always_ff @(posedge clk) begin
        if (!rst) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start) begin
            active <= 1'b1;
            count  <= '0;
        end else if (done) begin
            active <= 1'b0;
        end else if (active) begin
            count  <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op    <= funct3;
            neg_q <= lhs_neg ^ rhs_neg;
            neg_r <= lhs_neg;
            opnd  <= is_div_op(funct3) ? rhs_mag : lhs_mag;
            acc   <= {{XLEN{1'b0}}, (is_div_op(funct3) ? lhs_mag : rhs_mag)};
        end else if (active && !done) begin
            acc   <= is_div_op(op) ? step_div : step_mul;
        end
    end

endmodule

// File: rtl/arithmetic_muldiv.sv
// Execute-stage integer unit: single-cycle RV base ALU ops plus iterative M-extension
// multiply/divide, with valid/ready handshakes on both sides.
module arithmetic_muldiv
    import arithmetic_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHAMT_MASK = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    input  logic [2:0]      operation,
    input  logic [6:0]      metadata,
    input  logic            lhs_valid,
    input  logic            rhs_valid,
    input  logic            operation_valid,
    input  logic            metadata_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            illegal
);

    localparam logic [XLEN-1:0] SHIFT_MASK = XLEN'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    state_t                 state;
    kind_t                  kind;
    logic [XLEN-1:0]        quick;
    logic [XLEN-1:0]        shamt;
    logic [XLEN-1:0]        md_result;
    logic                   md_done;
    logic                   md_start;
    logic                   accept;
    logic signed [XLEN-1:0] lhs_s;
    logic signed [XLEN-1:0] rhs_s;

    assign lhs_s    = lhs;
    assign rhs_s    = rhs;
    // Legacy mode shifts by the whole rhs so oversized amounts flush to zero / sign
    assign shamt    = (SHAMT_MASK != 0) ? (rhs & SHIFT_MASK) : rhs;
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && result_ready);
    assign accept   = lhs_valid && rhs_valid && operation_valid && metadata_valid && in_ready;
    assign md_start = accept && (kind == K_ITER);

    always_comb begin
        kind  = K_ILLEGAL;
        quick = '0;
        case (metadata)
            F7_BASE: begin
                kind = K_QUICK;
                case (operation)
                    F3_ADD:  quick = lhs + rhs;
                    F3_SLL:  quick = lhs << shamt;
                    F3_SLT:  quick = {{(XLEN-1){1'b0}}, (lhs_s < rhs_s)};
                    F3_SLTU: quick = {{(XLEN-1){1'b0}}, (lhs < rhs)};
                    F3_XOR:  quick = lhs ^ rhs;
                    F3_SRL:  quick = lhs >> shamt;
                    F3_OR:   quick = lhs | rhs;
                    default: quick = lhs & rhs;
                endcase
            end
            F7_ALT: begin
                if (operation == F3_ADD) begin
                    kind  = K_QUICK;
                    quick = lhs - rhs;
                end else if (operation == F3_SRL) begin
                    kind  = K_QUICK;
                    quick = lhs_s >>> shamt;
                end
            end
            F7_MULDIV: begin
                kind = K_ITER;
                // Divide by zero and signed overflow retire immediately with fixed results
                if (is_div_op(operation)) begin
                    if (rhs == '0) begin
                        kind  = K_QUICK;
                        quick = (operation == F3_REM || operation == F3_REMU) ? lhs : '1;
                    end else if ((operation == F3_DIV || operation == F3_REM)
                                 && lhs == MOST_NEG && rhs == '1) begin
                        kind  = K_QUICK;
                        quick = (operation == F3_REM) ? '0 : lhs;
                    end
                end
            end
            default: ;
        endcase
    end

    muldiv_iterative #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .funct3 (operation),
        .lhs    (lhs),
        .rhs    (rhs),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                ST_BUSY: begin
                    if (md_done) begin
                        result       <= md_result;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE, or DONE with the result being consumed this edge
                    if (state == ST_IDLE || result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                        if (accept) begin
                            case (kind)
                                K_ILLEGAL: illegal <= 1'b1;
                                K_ITER:    state   <= ST_BUSY;
                                default: begin
                                    result       <= quick;
                                    result_valid <= 1'b1;
                                    state        <= ST_DONE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arithmetic_muldiv.sv
// Bench for arithmetic_muldiv: directed and random operations against an arithmetic reference model.
module tb_arithmetic_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] lhs = '0;
    logic [31:0] rhs = '0;
    logic [2:0]  operation = '0;
    logic [6:0]  metadata = '0;
    logic        lhs_valid = 1'b0;
    logic        rhs_valid = 1'b0;
    logic        operation_valid = 1'b0;
    logic        metadata_valid = 1'b0;
    logic        result_ready = 1'b0;

    logic        in_ready, result_valid, illegal;
    logic [31:0] result;
    logic        in_ready_l, result_valid_l, illegal_l;
    logic [31:0] result_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arithmetic_muldiv #(.XLEN(32), .SHAMT_MASK(1)) dut (
        .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .lhs_valid(lhs_valid), .rhs_valid(rhs_valid), .operation_valid(operation_valid),
        .metadata_valid(metadata_valid), .in_ready(in_ready), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .illegal(illegal)
    );

    arithmetic_muldiv #(.XLEN(32), .SHAMT_MASK(0)) dut_legacy (
        .clk(clk), .rst(rst), .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .lhs_valid(lhs_valid), .rhs_valid(rhs_valid), .operation_valid(operation_valid),
        .metadata_valid(metadata_valid), .in_ready(in_ready_l), .result(result_l),
        .result_valid(result_valid_l), .result_ready(result_ready), .illegal(illegal_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_valids(input logic v);
        lhs_valid       = v;
        rhs_valid       = v;
        operation_valid = v;
        metadata_valid  = v;
    endtask

    // Reference: RISC-V semantics computed with plain 64-bit arithmetic
    function automatic void model(input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b, input bit legacy,
                                  output bit legal, output bit iter, output logic [31:0] r);
        longint      sa, sb, p;
        logic [63:0] up;
        bit          big, ovf;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        big   = legacy && (b >= 32);
        ovf   = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        legal = 1'b1;
        iter  = 1'b0;
        r     = '0;
        p     = 0;
        up    = '0;
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
            case (f3)
                3'd0: r = f7[5] ? a - b : a + b;
                3'd1: r = big ? 32'd0 : a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) r = big ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
                    else       r = big ? 32'd0 : a >> b[4:0];
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h01) begin
            iter = 1'b1;
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
                3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
                3'd4: begin
                    if (b == 0)   begin r = '1; iter = 1'b0; end
                    else if (ovf) begin r = a;  iter = 1'b0; end
                    else r = 32'(sa / sb);
                end
                3'd5: begin
                    if (b == 0) begin r = '1; iter = 1'b0; end
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0)   begin r = a;  iter = 1'b0; end
                    else if (ovf) begin r = '0; iter = 1'b0; end
                    else r = 32'(sa % sb);
                end
                default: begin
                    if (b == 0) begin r = a; iter = 1'b0; end
                    else r = a % b;
                end
            endcase
        end else begin
            legal = 1'b0;
        end
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b);
        bit          legal, iter, legal_l, iter_l;
        logic [31:0] exp, exp_l;
        int          n, lat;
        model(f3, f7, a, b, 1'b0, legal, iter, exp);
        model(f3, f7, a, b, 1'b1, legal_l, iter_l, exp_l);
        @(negedge clk);
        result_ready = 1'b1;
        lhs = a; rhs = b; operation = f3; metadata = f7;
        set_valids(1'b1);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        set_valids(1'b0);
        if (!legal) begin
            check({tag, "_illegal_pulse"}, 32'(illegal), 32'd1);
            check({tag, "_illegal_novalid"}, 32'(result_valid), 32'd0);
            check({tag, "_illegal_ready"}, 32'(in_ready), 32'd1);
            @(negedge clk);
            check({tag, "_illegal_end"}, {30'd0, illegal, result_valid}, 32'd0);
        end else begin
            lat = 1;
            while (!result_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check({tag, "_latency"}, 32'(lat), iter ? 32'd34 : 32'd1);
            check({tag, "_result"}, result, exp);
            check({tag, "_legacy_valid"}, 32'(result_valid_l), 32'd1);
            check({tag, "_legacy_result"}, result_l, exp_l);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hffff_ffff;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 4))
            0:       return 7'h00;
            1:       return 7'h20;
            2, 3:    return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          lg, it, seen;
        logic [31:0] a, b, exp, held;
        int          lat;

        // reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_result", result, 32'd0);

        // directed cases
        run_op("add_wrap", 3'd0, 7'h00, 32'h0000_0001, 32'hffff_ffff);
        run_op("illegal_alt7", 3'd7, 7'h20, 32'h1234_5678, 32'h9abc_def0);
        run_op("sll_32", 3'd1, 7'h00, 32'hf2f8_3107, 32'h0000_0020);
        run_op("sra_4", 3'd5, 7'h20, 32'ha863_201f, 32'd4);
        run_op("sra_40", 3'd5, 7'h20, 32'ha863_201f, 32'd40);
        run_op("mulh_m1", 3'd1, 7'h01, 32'hffff_ffff, 32'hffff_ffff);
        run_op("mulhu_m1", 3'd3, 7'h01, 32'hffff_ffff, 32'hffff_ffff);
        run_op("div_neg", 3'd4, 7'h01, 32'hffff_fff9, 32'd2);
        run_op("rem_neg", 3'd6, 7'h01, 32'hffff_fff9, 32'd2);
        run_op("divu_zero", 3'd5, 7'h01, 32'h1357_9bdf, 32'd0);
        run_op("div_ovf", 3'd4, 7'h01, 32'h8000_0000, 32'hffff_ffff);
        run_op("rem_ovf", 3'd6, 7'h01, 32'h8000_0000, 32'hffff_ffff);

        // full-rate burst of base operations
        @(negedge clk);
        result_ready = 1'b1;
        metadata = 7'h00;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            lhs = a; rhs = b; operation = 3'(i);
            set_valids(1'b1);
            model(3'(i), 7'h00, a, b, 1'b0, lg, it, exp);
            check("burst_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            check("burst_valid", 32'(result_valid), 32'd1);
            check("burst_result", result, exp);
        end
        set_valids(1'b0);
        @(negedge clk);
        check("burst_drain", 32'(result_valid), 32'd0);

        // backpressure on a MUL, then a back-to-back ADD on the releasing edge
        a = $urandom;
        b = $urandom;
        model(3'd0, 7'h01, a, b, 1'b0, lg, it, exp);
        result_ready = 1'b0;
        lhs = a; rhs = b; operation = 3'd0; metadata = 7'h01;
        set_valids(1'b1);
        @(negedge clk);
        set_valids(1'b0);
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd34);
        check("bp_result", result, exp);
        held = exp;
        lhs = 32'h0000_1000; rhs = 32'h0000_0234; operation = 3'd0; metadata = 7'h00;
        set_valids(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_result", result, held);
            check("bp_hold_valid", 32'(result_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        result_ready = 1'b1;
        @(negedge clk);
        set_valids(1'b0);
        check("b2b_valid", 32'(result_valid), 32'd1);
        check("b2b_result", result, 32'h0000_1234);
        @(negedge clk);
        check("b2b_drain", 32'(result_valid), 32'd0);

        // reset while iterating abandons the operation
        lhs = $urandom; rhs = $urandom; operation = 3'd3; metadata = 7'h01;
        set_valids(1'b1);
        @(negedge clk);
        set_valids(1'b0);
        repeat (5) @(negedge clk);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rst_busy_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid || result_valid_l) seen = 1'b1;
        end
        check("rst_busy_no_result", 32'(seen), 32'd0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 3'($urandom), pick_f7(), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
